// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file and its clear engine.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned ZERO_IDX   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } clear_state_e;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential bulk-clear engine: walks every entry once, then pulses clear_done for one cycle.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_idx
);

  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  clear_state_e      state;
  clear_state_e      state_next;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_next;

  // State and sweep pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // Next state; the pointer wraps back to 0 on the last entry, so it never overruns
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      ST_IDLE: begin
        if (clear_req) begin
          state_next = ST_SWEEP;
          ptr_next   = '0;
        end
      end
      ST_SWEEP: begin
        ptr_next = ptr + ADDR_W'(1);
        if (ptr == PTR_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Moore outputs decoded straight from the state register
  always_comb begin
    clear_busy = 1'b0;
    clear_done = 1'b0;
    sweep_we   = 1'b0;
    sweep_idx  = ptr;
    case (state)
      ST_SWEEP: begin
        clear_busy = 1'b1;
        sweep_we   = 1'b1;
      end
      ST_DONE: begin
        clear_busy = 1'b1;
        clear_done = 1'b1;
      end
      default: begin
        clear_busy = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/reg_file_param.sv
// Decode-stage register file: two registered read ports with optional write bypass,
// optional hardwired zero entry, load-use pending scoreboard and a bulk-clear engine.
module reg_file_param
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] reg1,
  input  logic [ADDR_W-1:0] reg2,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] writeReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_reg,
  output logic              busy1,
  output logic              busy2,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done
);

  localparam int unsigned       DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADR = ADDR_W'(ZERO_IDX);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_idx;
  logic              wr_ok;
  logic              claim_ok;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;

  regfile_clear_fsm #(
    .ADDR_W(ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .clear_busy(clear_busy),
    .clear_done(clear_done),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  // Writes and claims only land while the clear engine is idle
  assign wr_ok    = RegWrite && !clear_busy && !(ZERO_REG && (writeReg == ZERO_ADR));
  assign claim_ok = claim_en && !clear_busy && !(ZERO_REG && (claim_reg == ZERO_ADR));

  // Read select: zero entry beats bypass beats storage
  always_comb begin
    rdata1 = mem[reg1];
    if (BYPASS && wr_ok && (writeReg == reg1)) begin
      rdata1 = WriteData;
    end
    if (ZERO_REG && (reg1 == ZERO_ADR)) begin
      rdata1 = '0;
    end
  end

  always_comb begin
    rdata2 = mem[reg2];
    if (BYPASS && wr_ok && (writeReg == reg2)) begin
      rdata2 = WriteData;
    end
    if (ZERO_REG && (reg2 == ZERO_ADR)) begin
      rdata2 = '0;
    end
  end

  // Storage array; the sweep and normal writes are mutually exclusive by construction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (wr_ok) begin
      mem[writeReg] <= WriteData;
    end
  end

  // Pending scoreboard; a same-cycle claim overrides the write's clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending <= '0;
    end else begin
      if (sweep_we) begin
        pending[sweep_idx] <= 1'b0;
      end
      if (wr_ok) begin
        pending[writeReg] <= 1'b0;
      end
      if (claim_ok) begin
        pending[claim_reg] <= 1'b1;
      end
    end
  end

  // Registered read ports, held while rd_en is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      read1 <= '0;
      read2 <= '0;
    end else if (rd_en) begin
      read1 <= rdata1;
      read2 <= rdata2;
    end
  end

  assign busy1 = pending[reg1];
  assign busy2 = pending[reg2];

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the CPU register file, used in the datapath decode stage. It provides two registered read ports with write-to-read bypass and an optional hardwired zero register. It adds a per-register pending scoreboard for load-use hazard detection and a sequential bulk-clear engine for context reset without a global reset.

Parameters:
DATA_W, 32, width of each register
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
ZERO_REG, 1, 1 = entry 0 always reads 0 and ignores writes and claims
BYPASS, 1, 1 = same-cycle write data is forwarded to read outputs

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rd_en  in  1  capture read ports this cycle
reg1  in  ADDR_W  read index 1
reg2  in  ADDR_W  read index 2
read1  out  DATA_W  registered read data 1
read2  out  DATA_W  registered read data 2
RegWrite  in  1  write strobe
writeReg  in  ADDR_W  write index
WriteData  in  DATA_W  write data
claim_en  in  1  mark claim_reg as pending (load issued)
claim_reg  in  ADDR_W  index to mark pending
busy1  out  1  pending[reg1], combinational
busy2  out  1  pending[reg2], combinational
clear_req  in  1  start bulk clear
clear_busy  out  1  high while the sweep runs
clear_done  out  1  one-cycle pulse when the sweep completes

Behaviour:
- Reset (reset=0, asynchronous):
  - all entries 0, all pending bits 0
  - read1=read2=0
  - FSM to IDLE, pointer 0, clear_busy=0, clear_done=0
- Write accepted when RegWrite=1, state=IDLE, and not (ZERO_REG and writeReg==0).
  - At the clock edge: mem[writeReg]<=WriteData; pending[writeReg]<=0.
- Claim accepted when claim_en=1, state=IDLE, and not (ZERO_REG and claim_reg==0).
  - Sets pending[claim_reg].
  - Claim and accepted write to the same index in the same cycle: pending ends at 1 (the new claim wins).
- Read: 1-cycle latency.
  - At the edge with rd_en=1, readN <= value selected by priority:
    - 0 if ZERO_REG and regN==0;
    - else WriteData if BYPASS and a write to regN is accepted this cycle;
    - else mem[regN].
  - rd_en=0: read1/read2 hold.
  - BYPASS=0: reads return the pre-write value.
- busyN = pending[regN], purely combinational.
  - No same-cycle forwarding into busy.
  - busyN is always 0 for index 0 when ZERO_REG=1.
- Clear FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on clear_req=1; pointer<=0.
  - SWEEP, each cycle: mem[ptr]<=0, pending[ptr]<=0, ptr++.
  - At ptr==DEPTH-1, after clearing -> DONE.
  - DONE: clear_done=1 for exactly one cycle -> IDLE.
  - Sweep length is DEPTH cycles; clear_done is asserted DEPTH+1 edges after the clear_req edge.
  - clear_busy=1 in SWEEP and DONE.
  - During SWEEP/DONE: writes and claims are dropped and clear_req is ignored. Reads still operate, return current mem contents, and bypass is disabled.
  - clear_req in the DONE cycle is ignored; clear_req in IDLE the cycle after DONE starts a new sweep.
  - Pointer wraps naturally at ADDR_W bits; it must not overrun.
- Reset mid-sweep: sweep aborts immediately, FSM to IDLE, everything cleared, no clear_done pulse.
- All arithmetic is unsigned; the pointer is ADDR_W bits wide.

Decomposition:
- Package regfile_pkg holds:
  - the FSM state typedef (IDLE/SWEEP/DONE);
  - default DATA_W/ADDR_W constants;
  - a ZERO_IDX constant.
- One natural sub-module: regfile_clear_fsm. It owns the state and pointer and outputs clear_busy, clear_done, sweep_we and sweep_idx.
- Storage, bypass muxing and the scoreboard stay in the top module.

Test Plan:
- Write/read with bypass:
  - Write 0xDEADBEEF to r5 with rd_en=1 and reg1=5 in the same cycle -> read1=0xDEADBEEF one edge later.
  - Repeat with BYPASS=0 -> read1=0.
- Zero register: write 0x1234 to r0, then read r0 -> read1=0. Claim r0 -> busy1 stays 0.
- Scoreboard:
  - claim r7 -> busy1=1 (reg1=7) after the edge.
  - Write r7 -> busy1=0.
  - Claim and write r7 in the same cycle -> busy1=1.
- Bulk clear:
  - Fill all 32 entries with nonzero values and claim r3, then pulse clear_req.
  - clear_busy is high for 33 cycles; clear_done pulses on edge 33.
  - A write to r9 during the sweep is dropped.
  - All reads then return 0 and busy is 0 everywhere.
- Reset mid-sweep: assert reset=0 at sweep cycle 10 -> outputs 0 immediately, clear_busy=0, no clear_done; a normal write after release succeeds.
- Hold: with rd_en=0 while reg1 changes and writes occur -> read1 keeps its last captured value.
